// File: rtl/pdm_chan_scheduler_pkg.sv
// Shared types and defaults for the PDM channel scheduler.
package pdm_pkg;
    localparam int NCH_DEF = 20;
    localparam int W_DEF   = 16;

    typedef enum logic {IDLE, SEND} sched_state_t;

    typedef logic [W_DEF-1:0] sample_t;
endpackage

// File: rtl/pdm_chan_scheduler_mask_next.sv
// Lowest-set-bit finder over a channel mask, plus any / exactly-one flags.
import pdm_pkg::*;

module chan_mask_next #(
    parameter int NCH = NCH_DEF,
    parameter int CW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] mask,
    output logic [CW-1:0]  idx,
    output logic           any,
    output logic           one_hot_only
);
    always_comb begin
        idx = '0;
        // Descending scan so the lowest set bit is the last assignment.
        for (int k = NCH - 1; k >= 0; k--) begin
            if (mask[k]) idx = CW'(k);
        end
        any          = |mask;
        one_hot_only = any && ((mask & (mask - NCH'(1))) == '0);
    end
endmodule

// File: rtl/pdm_chan_scheduler.sv
// Snapshots all CIC channel outputs on each strobe and streams the enabled
// ones, lowest channel first, to the shared halfband stage.
import pdm_pkg::*;

module pdm_chan_scheduler #(
    parameter int NCH = NCH_DEF,
    parameter int W   = W_DEF,
    parameter int CW  = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           sample_stb,
    input  logic [NCH*W-1:0] ch_data,
    input  logic [NCH-1:0] ch_mask,
    input  logic           clr_ovr,
    output logic [W-1:0]   m_data,
    output logic [CW-1:0]  m_chan,
    output logic           m_valid,
    input  logic           m_ready,
    output logic           m_last,
    output logic           busy,
    output logic           overrun,
    output logic [15:0]    frame_cnt
);
    sched_state_t state, state_d;

    logic [NCH-1:0][W-1:0] snap;
    logic [NCH-1:0]        mask_q;
    logic [NCH-1:0]        mask_clr;

    logic [CW-1:0] first_idx, next_idx, cur_idx;
    logic          first_any, next_any, cur_any, next_one, first_one;
    logic          hs, last_hs, accept, ovr_evt;

    assign mask_clr = mask_q & ~(NCH'(1) << m_chan);

    chan_mask_next #(.NCH(NCH), .CW(CW)) u_first (
        .mask(ch_mask), .idx(first_idx), .any(first_any), .one_hot_only(first_one)
    );
    chan_mask_next #(.NCH(NCH), .CW(CW)) u_next (
        .mask(mask_clr), .idx(next_idx), .any(next_any), .one_hot_only(next_one)
    );
    // Only the one-hot flag of the live mask is used; it drives m_last.
    chan_mask_next #(.NCH(NCH), .CW(CW)) u_cur (
        .mask(mask_q), .idx(cur_idx), .any(cur_any), .one_hot_only(m_last)
    );

    assign m_valid = (state == SEND);
    assign busy    = (state == SEND);
    assign m_data  = snap[m_chan];

    always_comb begin
        state_d = state;
        hs      = m_valid && m_ready;
        last_hs = hs && m_last;
        // A strobe coinciding with the final handshake starts the next frame
        // back-to-back; any other strobe while sending is a lost frame.
        accept  = sample_stb && en && first_any && (state == IDLE || last_hs);
        ovr_evt = sample_stb && (state == SEND) && !last_hs;
        case (state)
            IDLE: if (accept) state_d = SEND;
            SEND: if (last_hs && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            snap      <= '0;
            mask_q    <= '0;
            m_chan    <= '0;
            overrun   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                snap   <= ch_data;
                mask_q <= ch_mask;
                m_chan <= first_idx;
            end else if (hs) begin
                mask_q <= mask_clr;
                m_chan <= next_idx;
            end
            if (last_hs) frame_cnt <= frame_cnt + 16'd1;
            if (ovr_evt)      overrun <= 1'b1;
            else if (clr_ovr) overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pdm_chan_scheduler.sv
// Randomized directed bench for pdm_chan_scheduler against a frame-queue model.
module tb_pdm_chan_scheduler;
    localparam int NCH = 20;
    localparam int W   = 16;
    localparam int CW  = $clog2(NCH);

    logic             clk = 1'b0;
    logic             rst, en, sample_stb, clr_ovr, m_ready;
    logic [NCH*W-1:0] ch_data;
    logic [NCH-1:0]   ch_mask;
    logic [W-1:0]     m_data;
    logic [CW-1:0]    m_chan;
    logic             m_valid, m_last, busy, overrun;
    logic [15:0]      frame_cnt;

    pdm_chan_scheduler #(.NCH(NCH), .W(W)) dut (
        .clk(clk), .rst(rst), .en(en), .sample_stb(sample_stb),
        .ch_data(ch_data), .ch_mask(ch_mask), .clr_ovr(clr_ovr),
        .m_data(m_data), .m_chan(m_chan), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .overrun(overrun), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [15:0] d;
    } word_t;

    word_t       q[$];
    logic        m_ovr;
    logic [15:0] m_fcnt;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rnd_data();
        for (int k = 0; k < NCH; k++) ch_data[k*W +: W] = W'($urandom);
    endtask

    // Compare outputs with the model, advance the model by the current inputs,
    // then move to just after the next rising edge.
    task automatic step();
        bit busy_m, hs, lhs;
        busy_m = (q.size() > 0);
        chk("m_valid", 32'(m_valid), 32'(busy_m));
        chk("busy", 32'(busy), 32'(busy_m));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
        if (busy_m) begin
            chk("m_chan", 32'(m_chan), 32'(q[0].ch));
            chk("m_data", 32'(m_data), 32'(q[0].d));
            chk("m_last", 32'(m_last), 32'(q.size() == 1));
        end else begin
            chk("m_last_idle", 32'(m_last), 32'd0);
        end
        if (rst) begin
            q.delete();
            m_ovr  = 1'b0;
            m_fcnt = '0;
        end else begin
            hs  = busy_m && m_ready;
            lhs = hs && (q.size() == 1);
            if (hs) void'(q.pop_front());
            if (lhs) m_fcnt++;
            if (sample_stb && en && (ch_mask != 0) && (!busy_m || lhs)) begin
                for (int k = 0; k < NCH; k++)
                    if (ch_mask[k]) q.push_back('{ch: k, d: ch_data[k*W +: W]});
            end
            if (sample_stb && busy_m && !lhs) m_ovr = 1'b1;
            else if (clr_ovr)                 m_ovr = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        sample_stb = 0; clr_ovr = 0; rst = 0;
    endtask

    initial begin
        rst = 1; en = 1; sample_stb = 0; clr_ovr = 0; m_ready = 1;
        ch_mask = '0; ch_data = '0;
        q.delete(); m_ovr = 0; m_fcnt = 0;
        @(posedge clk); #1;
        step();
        rst = 0;
        chk("rst_m_chan", 32'(m_chan), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        step();

        // Basic three-channel frame
        rnd_data();
        ch_data[0*W +: W] = 16'h0011;
        ch_data[1*W +: W] = 16'h0022;
        ch_data[2*W +: W] = 16'h0033;
        ch_mask = 20'h00007; sample_stb = 1;
        step();
        sample_stb = 0;
        for (int i = 0; i < 5; i++) begin rnd_data(); step(); end
        chk("basic_fcnt", 32'(frame_cnt), 32'd1);

        // Sparse mask, consumer ready one cycle in three, data churning
        ch_mask = (20'd1 << 5) | (20'd1 << 18); rnd_data(); sample_stb = 1;
        step();
        sample_stb = 0;
        for (int i = 0; i < 10; i++) begin
            m_ready = (i % 3 == 2); rnd_data(); ch_mask = 20'($urandom);
            step();
        end
        m_ready = 1;
        step();

        // Full mask at a 16-cycle strobe period overruns
        ch_mask = 20'hFFFFF;
        for (int i = 0; i < 64; i++) begin
            sample_stb = (i % 16 == 0); rnd_data();
            step();
        end
        idle_in();
        for (int i = 0; i < 6; i++) step();
        chk("ovr_sticky", 32'(overrun), 32'd1);
        clr_ovr = 1; step(); clr_ovr = 0;
        chk("ovr_cleared", 32'(overrun), 32'd0);

        // Strobe on the last handshake chains frames without overrun
        ch_mask = 20'h00003; rnd_data(); sample_stb = 1; step();
        sample_stb = 0; step();
        rnd_data(); sample_stb = 1; step();
        sample_stb = 0;
        chk("bnd_busy", 32'(busy), 32'd1);
        chk("bnd_ovr", 32'(overrun), 32'd0);
        for (int i = 0; i < 4; i++) step();

        // Strobes ignored with an empty mask or the scheduler disabled
        ch_mask = '0; sample_stb = 1; step();
        ch_mask = 20'h0F0F0; en = 0; step();
        sample_stb = 0; en = 1; step();
        chk("ign_valid", 32'(m_valid), 32'd0);

        // Reset in the middle of an eight-channel frame
        ch_mask = 20'h000FF; rnd_data(); sample_stb = 1; step();
        sample_stb = 0; step(); step(); step();
        rst = 1; step(); rst = 0;
        chk("mid_rst_chan", 32'(m_chan), 32'd0);
        chk("mid_rst_data", 32'(m_data), 32'd0);
        ch_mask = 20'h00F08; rnd_data(); sample_stb = 1; step();
        sample_stb = 0;
        for (int i = 0; i < 7; i++) step();

        // Random traffic; strobes carry a live mask with the block enabled
        for (int i = 0; i < 400; i++) begin
            rnd_data();
            sample_stb = ($urandom_range(0, 7) == 0);
            ch_mask    = 20'($urandom) & 20'($urandom);
            if (ch_mask == 0) ch_mask = 20'h1 << $urandom_range(0, NCH - 1);
            en         = sample_stb ? 1'b1 : 1'($urandom);
            m_ready    = ($urandom_range(0, 3) != 0);
            clr_ovr    = ($urandom_range(0, 15) == 0);
            step();
        end
        idle_in(); m_ready = 1;
        for (int i = 0; i < 25; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pdm_chan_scheduler.md
# pdm_chan_scheduler

Time-multiplexing scheduler that shares one halfband decimation stage across the microphone array's CIC channels. On each CIC output strobe it snapshots all channel outputs, then streams the enabled channels one word at a time, in ascending channel order, over a valid/ready interface. The downstream consumer is the shared HalfBand1 input. The block flags frames lost because the consumer stalled past the next strobe.

## Interface
Parameters:
- `NCH`, 20: number of CIC channels.
- `W`, 16: CIC output word width.
- `CW`, `$clog2(NCH)`: channel index width (derived).

Ports:
- `clk`  in  1  system clock (the PDM bit clock domain).
- `rst`  in  1  reset. Synchronous, active-high.
- `en`  in  1  scheduler enable; sampled only in IDLE.
- `sample_stb`  in  1  one-cycle pulse; all `ch_data` words are valid in this cycle.
- `ch_data`  in  NCH*W  flattened CIC outputs; channel k occupies `[k*W +: W]`.
- `ch_mask`  in  NCH  per-channel enable; bit k=1 includes channel k.
- `clr_ovr`  in  1  clears `overrun`.
- `m_data`  out  W  current channel sample.
- `m_chan`  out  CW  channel index of `m_data`.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accepts word.
- `m_last`  out  1  current word is the last enabled channel of the frame.
- `busy`  out  1  frame in progress (state SEND).
- `overrun`  out  1  sticky; a strobe arrived while a frame was still pending.
- `frame_cnt`  out  16  completed-frame counter, wraps 0xFFFF→0.

## Operation
- FSM states:
  - IDLE: `m_valid`=0. A frame is accepted when `sample_stb` && `en` && `|ch_mask` are all true. On acceptance, register the `ch_data` snapshot and the `ch_mask` snapshot, load `m_chan` with the lowest set mask bit, and go to SEND.
  - SEND: `m_valid`=1. A handshake occurs when `m_valid` && `m_ready`. On a handshake, clear that channel's bit in the mask snapshot and load `m_chan` with the next-lowest set bit. On the handshake where `m_last`=1, increment `frame_cnt` and go to IDLE.
- Frame-boundary exception: a `sample_stb` in the same cycle as the `m_last` handshake counts as a new frame acceptance (not an overrun), provided `en` && `|ch_mask`. The FSM stays in SEND with the new snapshot.
- A `sample_stb` in SEND other than that exception sets `overrun`. The strobe is dropped and the current frame continues unchanged.
- `m_last` = exactly one bit remaining in the mask snapshot.
- `m_data` = `snapshot[m_chan]`. It is stable while `m_valid` && !`m_ready`; `m_valid` never drops without a handshake.
- Conditions that ignore a strobe:
  - `ch_mask`=0 with a strobe: no frame, no overrun.
  - `en`=0: strobes ignored in IDLE. Deasserting `en` mid-frame does not abort the frame.
- `clr_ovr` clears `overrun`. If `clr_ovr` and an overrun event occur in the same cycle, the set wins.
- Changes to `ch_mask` and `ch_data` after acceptance do not affect the current frame.

## Timing
- Reset values: state IDLE, `m_valid`=0, `m_last`=0, `busy`=0, `overrun`=0, `frame_cnt`=0, `m_chan`=0, `m_data`=0, snapshot=0.
- Strobe accepted in cycle t → `m_valid`=1 with the first channel in cycle t+1.
- With `m_ready` held high, the block sends one word per cycle. A frame of K enabled channels occupies cycles t+1..t+K; `busy` falls at t+K+1 and `frame_cnt` updates at the same edge.
- Throughput requirement: K ≤ strobe period (16 clk for the 8/×2 CIC divider). With all 20 channels enabled at a 16-cycle period, overrun is guaranteed; document it, do not prevent it.
- `rst` mid-frame: next edge returns all registers to reset values and the partial frame is discarded.

## Structure
- Package `pdm_pkg`:
  - `NCH_DEF`, `W_DEF` constants.
  - `sched_state_t` enum {IDLE, SEND}.
  - Typedef for a W-bit sample word.
- Sub-module `chan_mask_next`: combinational lowest-set-bit finder over an NCH-bit mask. Outputs the index (CW bits), `any`, and `one_hot_only` (used for `m_last`).
- Top module: FSM, snapshot register array, mask register, counters.

## Test plan
- Basic frame: mask=0x00007 with channel data 0x0011/0x0022/0x0033, `m_ready`=1, strobe → words (0,0x0011), (1,0x0022), (2,0x0033,last) on 3 consecutive cycles; `frame_cnt`=1.
- Sparse mask with backpressure: mask=bit5|bit18, `m_ready` toggles 1-of-3 → `m_chan` 5 then 18, `m_data` stable during stalls, no drops.
- Overrun: mask=0xFFFFF, strobes every 16 cycles, `m_ready`=1 → `overrun`=1 at the second strobe, that frame dropped, `frame_cnt` counts only completed frames; `clr_ovr` → 0.
- Boundary strobe: strobe in the same cycle as the `m_last` handshake → no overrun, `busy` stays 1, next frame starts the following cycle.
- Ignores: `ch_mask`=0 or `en`=0 with a strobe → `m_valid` stays 0, `frame_cnt` and `overrun` unchanged.
- Reset mid-frame: `rst` during channel 3 of 8 → all outputs at reset values on the next cycle; a fresh strobe restarts from the lowest channel.
